// File: rtl/cpu_board_io_pkg.sv
// ============================================================================
// Module : cpu_board_io_pkg
// Brief  : Debounce state encodings, display-select codes and hex segment codes
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_board_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } dbnc_state_e;

  localparam logic [1:0] SEL_PC     = 2'b00;
  localparam logic [1:0] SEL_REG1   = 2'b01;
  localparam logic [1:0] SEL_REG2   = 2'b10;
  localparam logic [1:0] SEL_RESULT = 2'b11;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

`default_nettype wire

// File: rtl/cpu_board_io_hex_to_seg7.sv
// ============================================================================
// Module : hex_to_seg7
// Brief  : Combinational hex nibble to active-low seven-segment {g..a} decoder
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hex_to_seg7
  import cpu_board_io_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_board_io.sv
// ============================================================================
// Module : cpu_board_io
// Brief  : Step-button debouncer and 4-digit multiplexed hex display of CPU debug values
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_board_io
  import cpu_board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_DIV     = 100000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        step_btn,
  input  logic [1:0]  sel,
  input  logic [31:0] PCout,
  input  logic [31:0] PCin,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic [31:0] result,
  input  logic [31:0] DataOut,
  input  logic [4:0]  reg1_addr,
  input  logic [4:0]  reg2_addr,
  output logic        cpu_step,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);

  logic              sync1_q, sync2_q;
  dbnc_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic [1:0]        digit_idx_q, digit_idx_d;
  logic [15:0]       snapshot_q, snapshot_d;
  logic              load_pending_q, load_pending_d;
  logic [3:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic [15:0]       disp;
  logic [6:0]        seg_raw;
  logic              btn_s;
  logic              ref_wrap;

  // Only the low byte of each CPU word reaches the display
  logic unused_bits;
  assign unused_bits = ^{PCout[31:8], PCin[31:8], ReadData1[31:8], ReadData2[31:8],
                         result[31:8], DataOut[31:8]};

  assign btn_s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d = ST_WAIT_PRESS;
          cnt_d   = '0;
        end
      end
      ST_WAIT_PRESS: begin
        if (!btn_s)              state_d = ST_IDLE;
        else if (cnt_q == CNT_MAX) state_d = ST_PRESSED;
        else                     cnt_d = cnt_q + CNT_W'(1);
      end
      ST_PRESSED: begin
        state_d = ST_WAIT_RELEASE;
        cnt_d   = '0;
      end
      ST_WAIT_RELEASE: begin
        if (btn_s)               cnt_d = '0;
        else if (cnt_q == CNT_MAX) state_d = ST_IDLE;
        else                     cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cpu_step = (state_q == ST_PRESSED);

  always_comb begin
    disp = {PCout[7:0], PCin[7:0]};
    case (sel)
      SEL_PC:     disp = {PCout[7:0], PCin[7:0]};
      SEL_REG1:   disp = {3'b000, reg1_addr, ReadData1[7:0]};
      SEL_REG2:   disp = {3'b000, reg2_addr, ReadData2[7:0]};
      SEL_RESULT: disp = {result[7:0], DataOut[7:0]};
      default:    disp = {PCout[7:0], PCin[7:0]};
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (snapshot_q[{digit_idx_q, 2'b00} +: 4]),
    .seg    (seg_raw)
  );

  // Snapshot only reloads at frame end so a sel/data change never tears a frame
  always_comb begin
    ref_wrap       = (ref_cnt_q == REF_MAX);
    ref_cnt_d      = ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
    digit_idx_d    = ref_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
    snapshot_d     = snapshot_q;
    if (load_pending_q || (ref_wrap && digit_idx_q == 2'd3))
      snapshot_d = disp;
    load_pending_d = 1'b0;
    an_d           = ~(4'b0001 << digit_idx_q);
    seg_d          = {1'b1, seg_raw};
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      ref_cnt_q      <= '0;
      digit_idx_q    <= 2'd0;
      snapshot_q     <= 16'h0000;
      load_pending_q <= 1'b1;
      an_q           <= 4'b1111;
      seg_q          <= 8'hFF;
    end else begin
      sync1_q        <= step_btn;
      sync2_q        <= sync1_q;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ref_cnt_q      <= ref_cnt_d;
      digit_idx_q    <= digit_idx_d;
      snapshot_q     <= snapshot_d;
      load_pending_q <= load_pending_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_board_io.sv
// ============================================================================
// Module : tb_cpu_board_io
// Brief  : Directed self-checking bench for cpu_board_io
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_board_io;
  import cpu_board_io_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        step_btn = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [31:0] PCout = '0, PCin = '0, ReadData1 = '0, ReadData2 = '0, result = '0, DataOut = '0;
  logic [4:0]  reg1_addr = '0, reg2_addr = '0;
  logic        cpu_step;
  logic [3:0]  an;
  logic [7:0]  seg;

  int tests_run = 0;
  int tests_failed = 0;

  cpu_board_io #(.DEBOUNCE_CYCLES(4), .REFRESH_DIV(3)) dut (
    .CLK(CLK), .Reset(Reset), .step_btn(step_btn), .sel(sel),
    .PCout(PCout), .PCin(PCin), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .result(result), .DataOut(DataOut), .reg1_addr(reg1_addr), .reg2_addr(reg2_addr),
    .cpu_step(cpu_step), .an(an), .seg(seg)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int digit_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'b11000000;  4'h1: return 8'b11111001;
      4'h2: return 8'b10100100;  4'h3: return 8'b10110000;
      4'h4: return 8'b10011001;  4'h5: return 8'b10010010;
      4'h6: return 8'b10000010;  4'h7: return 8'b11111000;
      4'h8: return 8'b10000000;  4'h9: return 8'b10010000;
      4'hA: return 8'b10001000;  4'hB: return 8'b10000011;
      4'hC: return 8'b11000110;  4'hD: return 8'b10100001;
      4'hE: return 8'b10000110;  default: return 8'b10001110;
    endcase
  endfunction

  // Hold the button for 'hold' edges; edge k is the k-th edge after step_btn rises
  task automatic press(input int hold, output int pulses, output int first_edge);
    pulses = 0;
    first_edge = -1;
    step_btn = 1'b1;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (cpu_step) begin
        if (pulses == 0) first_edge = k;
        pulses++;
      end
    end
  endtask

  task automatic idle_cycles(input int n, output int pulses);
    pulses = 0;
    step_btn = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (cpu_step) pulses++;
    end
  endtask

  initial begin
    int pulses, first_edge, dig, guard;
    logic [3:0] seen;
    logic [15:0] val;
    logic seen3, new_frame;

    // 1. reset
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_an", an, 4'b1111);
      check("rst_seg", seg, 8'hFF);
      check("rst_step", cpu_step, 1'b0);
    end
    Reset = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      check("post_rst_onehot", digit_of(an) < 4, 1'b1);
    end

    // 4. static frame of 0x1216
    PCout = 32'h0000_0012;
    PCin  = 32'h0000_0016;
    sel   = 2'b00;
    repeat (24) tick();
    seen = 4'b0000;
    val  = 16'h1216;
    for (int k = 0; k < 12; k++) begin
      tick();
      dig = digit_of(an);
      check("pc_onehot", dig < 4, 1'b1);
      if (dig < 4) begin
        seen[dig] = 1'b1;
        check("pc_seg", seg, exp_seg(val[dig*4 +: 4]));
      end
    end
    check("pc_all_digits", seen, 4'hF);

    // 5. no tearing when sel changes mid-frame
    sel       = 2'b11;
    result    = 32'h0000_00AB;
    DataOut   = 32'h0000_00CD;
    reg1_addr = 5'h15;
    ReadData1 = 32'h0000_003E;
    repeat (24) tick();
    guard = 0;
    while (an != 4'b1101 && guard < 20) begin
      tick();
      guard++;
    end
    check("sync_digit1_found", an, 4'b1101);
    sel = 2'b01;
    seen3 = 1'b0;
    new_frame = 1'b0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (an == 4'b0111) seen3 = 1'b1;
      if (seen3 && an == 4'b1110) new_frame = 1'b1;
      val = new_frame ? 16'h153E : 16'hABCD;
      dig = digit_of(an);
      check("frame_onehot", dig < 4, 1'b1);
      if (dig < 4) check(new_frame ? "frame_new_seg" : "frame_old_seg", seg, exp_seg(val[dig*4 +: 4]));
    end
    check("frame_switched", new_frame, 1'b1);

    // 2. held press -> exactly one pulse at edge 6
    press(50, pulses, first_edge);
    check("hold_pulses", pulses, 1);
    check("hold_latency", first_edge, 6);
    idle_cycles(10, pulses);
    check("release_pulses", pulses, 0);
    press(20, pulses, first_edge);
    check("press2_pulses", pulses, 1);
    check("press2_latency", first_edge, 6);
    idle_cycles(10, pulses);

    // 3. bounce
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step_btn = (k == 0 || k == 1 || k == 3);
      tick();
      if (cpu_step) pulses++;
    end
    idle_cycles(15, first_edge);
    check("bounce_pulses", pulses + first_edge, 0);
    check("bounce_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // 6. reset while debouncing a press
    step_btn = 1'b1;
    repeat (5) tick();
    check("wp_state", 32'(dut.state_q), 32'(ST_WAIT_PRESS));
    check("wp_cnt", 32'(dut.cnt_q), 2);
    Reset = 1'b1;
    step_btn = 1'b0;
    tick();
    check("rst_wp_step", cpu_step, 1'b0);
    Reset = 1'b0;
    idle_cycles(12, pulses);
    check("rst_wp_no_pulse", pulses, 0);
    press(20, pulses, first_edge);
    check("after_rst_pulses", pulses, 1);
    check("after_rst_latency", first_edge, 6);
    idle_cycles(10, pulses);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
